// File: rtl/dnn_output_evaluator.sv
// Output-layer scoreboard: assembles the per-case mismatch mask from
// a_out/y_out slices, commits a correct/wrong verdict once per case and
// keeps saturating case/error counters plus a sliding-window correct count.
module dnn_output_evaluator #(
  parameter int cpc       = 18,
  parameter int w         = 1,
  parameter int n_out     = 16,
  parameter int window    = 100,
  parameter int cnt_width = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [$clog2(cpc)-1:0]       cycle_index,
  input  logic [w-1:0]                 a_out,
  input  logic [w-1:0]                 y_out,
  output logic                         case_done,
  output logic                         case_correct,
  output logic [n_out-1:0]             err_mask,
  output logic [cnt_width-1:0]         total_cases,
  output logic [cnt_width-1:0]         total_errors,
  output logic [$clog2(window+1)-1:0]  recent_correct,
  output logic                         window_full
);

  localparam int idx_w = $clog2(cpc);
  localparam int rc_w  = $clog2(window+1);
  localparam logic [idx_w-1:0] first_idx = idx_w'(2);
  localparam logic [idx_w-1:0] last_idx  = idx_w'(cpc-1);

  logic                armed;
  logic [n_out-1:0]    acc;
  logic [window-1:0]   win;
  logic [rc_w-1:0]     fill;

  logic                capture;
  logic                commit;
  logic [31:0]         offset;
  logic [n_out-1:0]    slice;
  logic [n_out-1:0]    merged;
  logic                new_bit;

  // Beat qualification and the mask as it would look after merging this beat.
  always_comb begin
    capture = armed && (cycle_index >= first_idx) && (cycle_index <= last_idx);
    commit  = capture && (cycle_index == last_idx);
    offset  = '0;
    slice   = '0;
    if (capture) begin
      offset = (32'(cycle_index) - 32'd2) * 32'(w);
      slice  = n_out'(a_out ^ y_out) << offset;
    end
    merged  = acc | slice;
    new_bit = ~|merged;
  end

  // Arm on the first cycle_index==0 so the case in flight at reset release is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else if (cycle_index == '0) begin
      armed <= 1'b1;
    end
  end

  // Mismatch accumulator: merge captured beats, empty it at commit or clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear || commit) begin
      acc <= '0;
    end else if (capture) begin
      acc <= merged;
    end
  end

  // Committed-case statistics and the sliding window of verdicts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      case_done      <= 1'b0;
      case_correct   <= 1'b0;
      err_mask       <= '0;
      total_cases    <= '0;
      total_errors   <= '0;
      recent_correct <= '0;
      window_full    <= 1'b0;
      win            <= '0;
      fill           <= '0;
    end else if (clear) begin
      case_done      <= 1'b0;
      case_correct   <= 1'b0;
      err_mask       <= '0;
      total_cases    <= '0;
      total_errors   <= '0;
      recent_correct <= '0;
      window_full    <= 1'b0;
      win            <= '0;
      fill           <= '0;
    end else begin
      case_done <= commit;
      if (commit) begin
        err_mask     <= merged;
        case_correct <= new_bit;
        if (total_cases != '1) begin
          total_cases <= total_cases + cnt_width'(1);
        end
        if (!new_bit && (total_errors != '1)) begin
          total_errors <= total_errors + cnt_width'(1);
        end
        // The oldest bit is still zero while the window is filling, so the
        // same add/subtract form covers both the filling and rolling phases.
        recent_correct <= recent_correct + rc_w'(new_bit) - rc_w'(win[window-1]);
        win            <= {win[window-2:0], new_bit};
        if (!window_full) begin
          fill <= fill + rc_w'(1);
          if (fill == rc_w'(window-1)) begin
            window_full <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dnn_output_evaluator.sv
// Randomized directed bench for dnn_output_evaluator with a case-level
// reference model; a second narrow-counter instance exercises saturation.
module tb_dnn_output_evaluator;

  localparam int CPC  = 18;
  localparam int W    = 1;
  localparam int NOUT = 16;
  localparam int WIN  = 100;
  localparam int CW   = 32;
  localparam int SCW  = 4;
  localparam int SMAX = (1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic [4:0]      cycle_index;
  logic [W-1:0]    a_out;
  logic [W-1:0]    y_out;

  logic            case_done, case_correct, window_full;
  logic [NOUT-1:0] err_mask;
  logic [CW-1:0]   total_cases, total_errors;
  logic [6:0]      recent_correct;

  logic            s_case_done, s_case_correct, s_window_full;
  logic [NOUT-1:0] s_err_mask;
  logic [SCW-1:0]  s_total_cases, s_total_errors;
  logic [6:0]      s_recent_correct;

  dnn_output_evaluator #(.cpc(CPC), .w(W), .n_out(NOUT), .window(WIN), .cnt_width(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cycle_index(cycle_index),
    .a_out(a_out), .y_out(y_out), .case_done(case_done), .case_correct(case_correct),
    .err_mask(err_mask), .total_cases(total_cases), .total_errors(total_errors),
    .recent_correct(recent_correct), .window_full(window_full));

  dnn_output_evaluator #(.cpc(CPC), .w(W), .n_out(NOUT), .window(WIN), .cnt_width(SCW)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .cycle_index(cycle_index),
    .a_out(a_out), .y_out(y_out), .case_done(s_case_done), .case_correct(s_case_correct),
    .err_mask(s_err_mask), .total_cases(s_total_cases), .total_errors(s_total_errors),
    .recent_correct(s_recent_correct), .window_full(s_window_full));

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: state of the statistics after each whole case.
  longint          m_cases, m_errs;
  int              s_cases, s_errs;
  bit              q[$];
  logic [NOUT-1:0] m_mask;
  bit              m_correct;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_recent();
    int s = 0;
    foreach (q[k]) s += int'(q[k]);
    return s;
  endfunction

  task automatic model_clear();
    m_cases = 0; m_errs = 0; s_cases = 0; s_errs = 0;
    m_mask = '0; m_correct = 1'b0;
    q.delete();
  endtask

  task automatic model_commit(input logic [NOUT-1:0] mask);
    m_mask    = mask;
    m_correct = (mask == '0);
    m_cases++;
    if (!m_correct) m_errs++;
    if (s_cases < SMAX) s_cases++;
    if (!m_correct && s_errs < SMAX) s_errs++;
    q.push_back(m_correct);
    if (q.size() > WIN) void'(q.pop_front());
  endtask

  task automatic check_all(input string tag, input bit done_exp);
    check({tag, ".case_done"},      case_done,      done_exp);
    check({tag, ".case_correct"},   case_correct,   m_correct);
    check({tag, ".err_mask"},       err_mask,       m_mask);
    check({tag, ".total_cases"},    total_cases,    m_cases);
    check({tag, ".total_errors"},   total_errors,   m_errs);
    check({tag, ".recent_correct"}, recent_correct, m_recent());
    check({tag, ".window_full"},    window_full,    (q.size() == WIN));
    check({tag, ".s_total_cases"},  s_total_cases,  s_cases);
    check({tag, ".s_total_errors"}, s_total_errors, s_errs);
  endtask

  // mode: 0 all match, 1 sparse random mismatches, 2 flip at flip_idx, 3 every bit wrong.
  task automatic run_case(input int mode, input int flip_idx, input int rst_at,
                          input bit clr_last, input int start);
    logic [NOUT-1:0] mask;
    bit cut;
    bit commit;
    mask = '0;
    cut  = 1'b0;
    for (int i = start; i < CPC; i++) begin
      cycle_index = 5'(i);
      y_out = W'($urandom);
      case (mode)
        0:       a_out = y_out;
        1:       a_out = y_out ^ (($urandom_range(0, 39) == 0) ? W'($urandom_range(1, (1 << W) - 1)) : W'(0));
        2:       a_out = (i == flip_idx) ? ~y_out : y_out;
        default: a_out = ~y_out;
      endcase
      if (i >= 2) mask[(i-2)*W +: W] = a_out ^ y_out;
      clear = clr_last && (i == CPC - 1);
      if (i == rst_at) begin
        reset = 1'b0;
        cut = 1'b1;
        model_clear();
        #1;
        check("async_reset.total_cases", total_cases, 0);
        check("async_reset.err_mask", err_mask, 0);
      end
      if (rst_at >= 0 && i == rst_at + 3) reset = 1'b1;
      @(posedge clk);
      #1;
      if (i < CPC - 1) check("no_early_done", case_done, 0);
    end
    clear = 1'b0;
    commit = !(start != 0 || cut || clr_last);
    if (clr_last) model_clear();
    if (commit) model_commit(mask);
    check_all("case", commit);
  endtask

  initial begin
    model_clear();
    reset = 1'b0; clear = 1'b0; cycle_index = '0; a_out = '0; y_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0);

    // Release mid-sweep: the partial case must not be committed.
    reset = 1'b1;
    run_case(0, -1, -1, 1'b0, 10);

    // Three matching cases.
    for (int c = 0; c < 3; c++) run_case(0, -1, -1, 1'b0, 0);
    check("all_match.total_cases", total_cases, 3);
    check("all_match.total_errors", total_errors, 0);
    check("all_match.recent_correct", recent_correct, 3);
    check("all_match.err_mask", err_mask, 0);

    // Single mismatch at cycle_index 7 -> neuron 5.
    run_case(2, 7, -1, 1'b0, 0);
    check("single.err_mask", err_mask, 16'h0020);
    check("single.case_correct", case_correct, 0);
    check("single.total_errors", total_errors, 1);

    // Random cases.
    for (int c = 0; c < 20; c++) run_case(1, -1, -1, 1'b0, 0);

    // Reset at cycle_index 9, released 3 cycles later.
    run_case(1, -1, 9, 1'b0, 0);
    run_case(0, -1, -1, 1'b0, 0);
    check("mid_reset.total_cases", total_cases, 1);

    // Clear colliding with the commit of the fifth case.
    for (int c = 0; c < 4; c++) run_case(1, -1, -1, 1'b0, 0);
    run_case(1, -1, -1, 1'b1, 0);
    check("clear.total_cases", total_cases, 0);
    check("clear.recent_correct", recent_correct, 0);

    // Window roll: 100 correct, then 5 wrong.
    run_case(0, -1, -1, 1'b0, 0);
    check("after_clear.total_cases", total_cases, 1);
    for (int c = 1; c < WIN - 1; c++) run_case(0, -1, -1, 1'b0, 0);
    check("roll.not_full_at_99", window_full, 0);
    run_case(0, -1, -1, 1'b0, 0);
    check("roll.full_at_100", window_full, 1);
    check("roll.recent_100", recent_correct, 100);
    for (int k = 1; k <= 5; k++) begin
      run_case(3, -1, -1, 1'b0, 0);
      check("roll.recent_dec", recent_correct, 64'(100 - k));
    end

    // Narrow counters saturate instead of wrapping.
    for (int c = 0; c < 12; c++) run_case(3, -1, -1, 1'b0, 0);
    check("sat.s_total_cases", s_total_cases, SMAX);
    check("sat.s_total_errors", s_total_errors, SMAX);

    for (int c = 0; c < 20; c++) run_case(1, -1, -1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/dnn_output_evaluator.md
# dnn_output_evaluator

Hardware scoreboard sitting directly downstream of the DNN output layer. It consumes the per-cycle output slice `a_out` and the matching ideal slice `y_out`, assembles one full output vector per training case, and flags the case correct or wrong. It keeps running statistics on chip: total cases, total errors, a per-case mismatch mask, and a sliding-window count of correct cases over the most recent `window` cases. This replaces the bench-side error accounting and makes on-board training progress observable.

## Interface
- `cpc`, 18: cycles per training case, equal to `n[0]*fo[0]/z[0] + 2`.
- `w`, 1: output bits per clock, equal to `z[L-2]/fi[L-2]`.
- `n_out`, 16: output neurons, equal to `n[L-1]`. Must equal `(cpc-2)*w`.
- `window`, 100: sliding-window depth in cases.
- `cnt_width`, 32: width of the case and error counters.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (low) clears all state immediately.
- `clear`  in  1  synchronous statistics clear, active-high.
- `cycle_index`  in  `$clog2(cpc)`  position within the case, from `cycle_block_counter`.
- `a_out`  in  `w`  actual output slice, thresholded to 1 bit per neuron.
- `y_out`  in  `w`  ideal output slice.
- `case_done`  out  1  one-cycle pulse marking that a case result has been committed.
- `case_correct`  out  1  result of the last committed case (1 = all bits matched).
- `err_mask`  out  `n_out`  mismatch bits of the last committed case; bit i corresponds to neuron i.
- `total_cases`  out  `cnt_width`  number of committed cases.
- `total_errors`  out  `cnt_width`  number of committed cases with at least one mismatch.
- `recent_correct`  out  `$clog2(window+1)`  number of correct cases among the last `min(total_cases, window)` cases.
- `window_full`  out  1  high once `window` cases have been committed since the last reset or clear.

## Operation
- **Reset values.** Every output resets to 0. The internal accumulator, the window shift register, and the `armed` flag also reset to 0.
- **Arming.** The block ignores all beats until it samples `cycle_index == 0`, which sets `armed`. This discards the partial case that is in flight when reset is released.
- **Beat capture.** A beat is captured when `armed` is high and `2 <= cycle_index <= cpc-1`. At each captured beat, the block ORs `a_out ^ y_out` into accumulator bits `[(cycle_index-2)*w +: w]`.
- **Commit.** A commit happens on the edge where the captured beat has `cycle_index == cpc-1`. On that edge:
  - The final slice is merged, and the merged result is written to `err_mask`.
  - `case_correct` is set to `~|merged`.
  - `total_cases` increments by 1.
  - `total_errors` increments by 1 if the case is wrong.
  - The window shift register takes in the `case_correct` bit.
  - The accumulator is zeroed.
- **Window update.** While the window is not full, `recent_correct` increases by the new bit. Once full, it changes by (new bit − bit shifted out), so its value stays within `0..window`. `window_full` sets when the window's fill count reaches `window`.
- **Saturation.** `total_cases` and `total_errors` saturate at all-ones; they never wrap.
- **Clear.** When `clear` is high, all statistics outputs, `err_mask`, `case_correct`, the window, and the accumulator go to 0 on that edge. `armed` is kept. If `clear` coincides with a commit, clear wins: the case is discarded and `case_done` stays low.
- **Unused indices.** Beats at `cycle_index` 0 or 1 are never merged.

## Timing
- Statistics latency is 1 cycle: `case_done` and the updated statistics are all visible in the cycle after the commit edge.
- `case_done` is high for exactly one cycle per committed case; successive pulses are `cpc` cycles apart.
- Outputs hold their values between commits.
- If reset is asserted mid-case, all state clears asynchronously. After release, the block re-arms at the next `cycle_index == 0`, so the interrupted case is never committed.
- `a_out` and `y_out` must be stable at the sampling edge. The block adds no extra input register stage.

## Test plan
- **All match.** Reset, then run 3 cases with `a_out == y_out` on every beat → 3 `case_done` pulses spaced 18 cycles apart; `total_cases=3`, `total_errors=0`, `recent_correct=3`, `err_mask=0`.
- **Single mismatch.** Flip `a_out` only at `cycle_index=7` → `err_mask=16'h0020`, `case_correct=0`, `total_errors=1`.
- **Window roll.** Run 100 correct cases, then 5 wrong ones → `window_full` rises at case 100; `recent_correct` reads 100, then 99, 98, 97, 96, 95.
- **Mid-case reset.** Assert reset at `cycle_index=9` and release 3 cycles later → no commit for the interrupted case; the first `case_done` follows the next full 0..17 sweep; `total_cases=1`.
- **Clear collision.** Assert `clear` on the commit edge after 4 cases → no `case_done`; all statistics read 0; the next case gives `total_cases=1`.
- **Saturation.** Force the counters to `32'hFFFFFFFE` and run 3 wrong cases → both counters read `32'hFFFFFFFF`.
